// File: rtl/inst_buf.sv
// In-order instruction buffer between decode and dispatch: a DEPTH-entry circular queue
// with per-lane credits and exception serialisation. Optional counters under IB_PERF_EN.
module inst_buf #(
  parameter int WIDTH = 3,
  parameter int ISSUE = 2,
  parameter int DEPTH = 8,
  parameter int OPT_W = 4,
  parameter int FUN_W = 4,
  parameter int SEL_W = 3,
  parameter int PC_W  = 32,
  parameter int IMM_W = 32,
  parameter int SRC_W = 10,
  parameter int DST_W = 5,
  parameter int EXC_W = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [WIDTH-1:0]         i_valid,
  input  logic [WIDTH*OPT_W-1:0]   i_opt,
  input  logic [WIDTH*FUN_W-1:0]   i_fun,
  input  logic [WIDTH*SEL_W-1:0]   i_sel,
  input  logic [WIDTH*PC_W-1:0]    i_pc,
  input  logic [WIDTH*IMM_W-1:0]   i_imm,
  input  logic [WIDTH*SRC_W-1:0]   i_src,
  input  logic [WIDTH*DST_W-1:0]   i_dst,
  input  logic [WIDTH*EXC_W-1:0]   i_exc,
  output logic [WIDTH-1:0]         o_avail,
  input  logic                     i_flush,
  output logic [ISSUE-1:0]         o_dis_valid,
  output logic [ISSUE*OPT_W-1:0]   o_dis_opt,
  output logic [ISSUE*FUN_W-1:0]   o_dis_fun,
  output logic [ISSUE*SEL_W-1:0]   o_dis_sel,
  output logic [ISSUE*PC_W-1:0]    o_dis_pc,
  output logic [ISSUE*IMM_W-1:0]   o_dis_imm,
  output logic [ISSUE*SRC_W-1:0]   o_dis_src,
  output logic [ISSUE*DST_W-1:0]   o_dis_dst,
  output logic [ISSUE*EXC_W-1:0]   o_dis_exc,
  input  logic [ISSUE-1:0]         i_dis_ready
`ifdef IB_PERF_EN
  ,
  output logic [31:0]              o_perf_full_cycles,
  output logic [$clog2(DEPTH+1)-1:0] o_perf_max_occ
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPT_W-1:0] opt;
    logic [FUN_W-1:0] fun;
    logic [SEL_W-1:0] sel;
    logic [PC_W-1:0]  pc;
    logic [IMM_W-1:0] imm;
    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
    logic [EXC_W-1:0] exc;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  entry_t             w_in [WIDTH];
  entry_t             w_rd [ISSUE];
  logic [CNT_W-1:0]   w_free;
  logic [WIDTH-1:0]   w_wr;
  logic [CNT_W-1:0]   w_enq;
  logic [CNT_W-1:0]   w_deq;
  logic               w_blocked;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_in[i].opt = i_opt[i*OPT_W +: OPT_W];
      w_in[i].fun = i_fun[i*FUN_W +: FUN_W];
      w_in[i].sel = i_sel[i*SEL_W +: SEL_W];
      w_in[i].pc  = i_pc[i*PC_W +: PC_W];
      w_in[i].imm = i_imm[i*IMM_W +: IMM_W];
      w_in[i].src = i_src[i*SRC_W +: SRC_W];
      w_in[i].dst = i_dst[i*DST_W +: DST_W];
      w_in[i].exc = i_exc[i*EXC_W +: EXC_W];
    end
  end

  // Credits come from registered occupancy only, so dequeues free slots a cycle later.
  always_comb begin
    w_free = CNT_W'(DEPTH) - r_count;
    w_enq  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_avail[i] = (w_free > CNT_W'(i));
      w_wr[i]    = i_valid[i] & o_avail[i];
      w_enq      = w_enq + CNT_W'(w_wr[i]);
    end
  end

  // An exception entry may only leave through lane 0, and nothing younger rides with it.
  always_comb begin
    w_blocked = 1'b0;
    w_deq     = '0;
    for (int j = 0; j < ISSUE; j++) begin
      w_rd[j] = r_mem[r_head + PTR_W'(j)];
    end
    for (int j = 0; j < ISSUE; j++) begin
      if (j > 0) begin
        w_blocked = w_blocked | (w_rd[j-1].exc != '0) | (w_rd[j].exc != '0);
      end
      o_dis_valid[j] = (r_count > CNT_W'(j)) & ~w_blocked;
      w_deq          = w_deq + CNT_W'(o_dis_valid[j] & i_dis_ready[j]);
    end
  end

  always_comb begin
    o_dis_opt = '0;
    o_dis_fun = '0;
    o_dis_sel = '0;
    o_dis_pc  = '0;
    o_dis_imm = '0;
    o_dis_src = '0;
    o_dis_dst = '0;
    o_dis_exc = '0;
    for (int j = 0; j < ISSUE; j++) begin
      o_dis_opt[j*OPT_W +: OPT_W] = w_rd[j].opt;
      o_dis_fun[j*FUN_W +: FUN_W] = w_rd[j].fun;
      o_dis_sel[j*SEL_W +: SEL_W] = w_rd[j].sel;
      o_dis_pc[j*PC_W +: PC_W]    = w_rd[j].pc;
      o_dis_imm[j*IMM_W +: IMM_W] = w_rd[j].imm;
      o_dis_src[j*SRC_W +: SRC_W] = w_rd[j].src;
      o_dis_dst[j*DST_W +: DST_W] = w_rd[j].dst;
      o_dis_exc[j*EXC_W +: EXC_W] = w_rd[j].exc;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_wr[i]) begin
          r_mem[r_tail + PTR_W'(i)] <= w_in[i];
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= r_count + w_enq - w_deq;
    end
  end

`ifdef IB_PERF_EN
  logic [31:0]      r_perf_full;
  logic [CNT_W-1:0] r_perf_max;

  // Statistics survive flush; only the hardware reset clears them.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_perf_full <= '0;
      r_perf_max  <= '0;
    end else begin
      if ((r_count == CNT_W'(DEPTH)) && (r_perf_full != '1)) begin
        r_perf_full <= r_perf_full + 32'd1;
      end
      if (r_count > r_perf_max) begin
        r_perf_max <= r_count;
      end
    end
  end

  assign o_perf_full_cycles = r_perf_full;
  assign o_perf_max_occ     = r_perf_max;
`endif

endmodule

// File: tb/tb_inst_buf.sv
// Self-checking bench for inst_buf: queue-based reference model plus directed literal checks
// and randomized traffic.
module tb_inst_buf;
  localparam int WIDTH = 3, ISSUE = 2, DEPTH = 8;
  localparam int OPT_W = 4, FUN_W = 4, SEL_W = 3, PC_W = 32, IMM_W = 32;
  localparam int SRC_W = 10, DST_W = 5, EXC_W = 4;

  typedef struct packed {
    logic [OPT_W-1:0] opt;
    logic [FUN_W-1:0] fun;
    logic [SEL_W-1:0] sel;
    logic [PC_W-1:0]  pc;
    logic [IMM_W-1:0] imm;
    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
    logic [EXC_W-1:0] exc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [WIDTH-1:0]       valid = '0;
  logic [WIDTH*OPT_W-1:0] in_opt;
  logic [WIDTH*FUN_W-1:0] in_fun;
  logic [WIDTH*SEL_W-1:0] in_sel;
  logic [WIDTH*PC_W-1:0]  in_pc;
  logic [WIDTH*IMM_W-1:0] in_imm;
  logic [WIDTH*SRC_W-1:0] in_src;
  logic [WIDTH*DST_W-1:0] in_dst;
  logic [WIDTH*EXC_W-1:0] in_exc;
  logic [WIDTH-1:0]       avail;
  logic [ISSUE-1:0]       dis_valid;
  logic [ISSUE*OPT_W-1:0] dis_opt;
  logic [ISSUE*FUN_W-1:0] dis_fun;
  logic [ISSUE*SEL_W-1:0] dis_sel;
  logic [ISSUE*PC_W-1:0]  dis_pc;
  logic [ISSUE*IMM_W-1:0] dis_imm;
  logic [ISSUE*SRC_W-1:0] dis_src;
  logic [ISSUE*DST_W-1:0] dis_dst;
  logic [ISSUE*EXC_W-1:0] dis_exc;
  logic [ISSUE-1:0]       dis_ready = '0;

  ent_t lane_e [WIDTH];
  ent_t mq [$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_buf dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid),
    .i_opt(in_opt), .i_fun(in_fun), .i_sel(in_sel), .i_pc(in_pc), .i_imm(in_imm),
    .i_src(in_src), .i_dst(in_dst), .i_exc(in_exc), .o_avail(avail), .i_flush(flush),
    .o_dis_valid(dis_valid), .o_dis_opt(dis_opt), .o_dis_fun(dis_fun), .o_dis_sel(dis_sel),
    .o_dis_pc(dis_pc), .o_dis_imm(dis_imm), .o_dis_src(dis_src), .o_dis_dst(dis_dst),
    .o_dis_exc(dis_exc), .i_dis_ready(dis_ready)
  );

  always_comb begin
    in_opt = '0; in_fun = '0; in_sel = '0; in_pc = '0;
    in_imm = '0; in_src = '0; in_dst = '0; in_exc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_opt[i*OPT_W +: OPT_W] = lane_e[i].opt;
      in_fun[i*FUN_W +: FUN_W] = lane_e[i].fun;
      in_sel[i*SEL_W +: SEL_W] = lane_e[i].sel;
      in_pc[i*PC_W +: PC_W]    = lane_e[i].pc;
      in_imm[i*IMM_W +: IMM_W] = lane_e[i].imm;
      in_src[i*SRC_W +: SRC_W] = lane_e[i].src;
      in_dst[i*DST_W +: DST_W] = lane_e[i].dst;
      in_exc[i*EXC_W +: EXC_W] = lane_e[i].exc;
    end
  end

  function automatic ent_t dis_ent(input int j);
    ent_t d;
    d.opt = dis_opt[j*OPT_W +: OPT_W];
    d.fun = dis_fun[j*FUN_W +: FUN_W];
    d.sel = dis_sel[j*SEL_W +: SEL_W];
    d.pc  = dis_pc[j*PC_W +: PC_W];
    d.imm = dis_imm[j*IMM_W +: IMM_W];
    d.src = dis_src[j*SRC_W +: SRC_W];
    d.dst = dis_dst[j*DST_W +: DST_W];
    d.exc = dis_exc[j*EXC_W +: EXC_W];
    return d;
  endfunction

  function automatic ent_t rand_ent(input logic [PC_W-1:0] pc, input logic [EXC_W-1:0] exc);
    ent_t e;
    e.opt = OPT_W'($urandom); e.fun = FUN_W'($urandom); e.sel = SEL_W'($urandom);
    e.imm = $urandom; e.src = SRC_W'($urandom); e.dst = DST_W'($urandom);
    e.pc = pc; e.exc = exc;
    return e;
  endfunction

  // Oldest entries go out in order; an exception entry only ever leaves alone from lane 0.
  function automatic int exp_nvalid();
    int n = 0;
    for (int j = 0; j < ISSUE; j++) begin
      if (j >= mq.size()) break;
      if (mq[j].exc != '0) begin
        if (j == 0) n = 1;
        break;
      end
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] ea;
    logic [ISSUE-1:0] ev;
    int n;
    ent_t d;
    for (int i = 0; i < WIDTH; i++) ea[i] = ((DEPTH - mq.size()) > i);
    n = exp_nvalid();
    for (int j = 0; j < ISSUE; j++) ev[j] = (j < n);
    chk("model_avail", 64'(avail), 64'(ea));
    chk("model_dis_valid", 64'(dis_valid), 64'(ev));
    for (int j = 0; j < n; j++) begin
      d = dis_ent(j);
      n_chk++;
      if (d !== mq[j]) begin
        n_err++;
        $display("FAIL model_lane%0d_entry: got pc 0x%0h exc %0d, expected pc 0x%0h exc %0d",
                 j, d.pc, d.exc, mq[j].pc, mq[j].exc);
      end
    end
  endtask

  task automatic step();
    int n, free, deq;
    ent_t add [$];
    if (flush) begin
      mq.delete();
    end else begin
      n = exp_nvalid();
      free = DEPTH - mq.size();
      deq = 0;
      for (int j = 0; j < n; j++) if (dis_ready[j]) deq++;
      for (int i = 0; i < WIDTH; i++) if (valid[i] && i < free) add.push_back(lane_e[i]);
      repeat (deq) void'(mq.pop_front());
      foreach (add[k]) mq.push_back(add[k]);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_lanes(input logic [WIDTH-1:0] v, input int base, input logic [EXC_W-1:0] exc1);
    valid = v;
    for (int i = 0; i < WIDTH; i++) begin
      lane_e[i] = rand_ent(PC_W'(base + 4 * i), (i == 1) ? exc1 : '0);
    end
  endtask

  task automatic rand_cycle(input bit allow_flush, inout int pc_ctr);
    int nv, nr;
    nv = $urandom_range(0, WIDTH);
    nr = $urandom_range(0, ISSUE);
    valid = WIDTH'((1 << nv) - 1);
    for (int i = 0; i < WIDTH; i++) begin
      lane_e[i] = rand_ent(PC_W'(pc_ctr),
                           ($urandom_range(0, 5) == 0) ? EXC_W'($urandom_range(1, 15)) : '0);
      pc_ctr += 4;
    end
    dis_ready = ISSUE'((1 << nr) - 1);
    flush = allow_flush && ($urandom_range(0, 31) == 0);
    step();
    flush = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int exp_pc, popped, pushed, pc_ctr;
    set_lanes('0, 0, '0);
    repeat (2) @(negedge clk);
    chk("reset_avail", 64'(avail), 64'h7);
    chk("reset_dis_valid", 64'(dis_valid), 64'h0);
    rst_n = 1'b1;
    check_outputs();

    // First push and the one-cycle latency to dispatch.
    set_lanes(3'b111, 'h100, '0);
    step();
    chk("first_dis_valid", 64'(dis_valid), 64'h3);
    chk("first_pc0", 64'(dis_pc[31:0]), 64'h100);
    chk("first_pc1", 64'(dis_pc[63:32]), 64'h104);

    // Fill with the consumer stalled.
    set_lanes(3'b111, 'h10c, '0);
    step();
    chk("fill_c3_avail", 64'(avail), 64'h3);
    set_lanes(3'b111, 'h118, '0);
    step();
    chk("fill_c4_avail", 64'(avail), 64'h0);

    // Full: enqueue refused while two entries drain.
    set_lanes(3'b111, 'h124, '0);
    dis_ready = 2'b11;
    step();
    chk("full_deq_avail", 64'(avail), 64'h3);
    chk("full_deq_head_pc", 64'(dis_pc[31:0]), 64'h108);

    set_lanes(3'b111, 'h130, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_avail", 64'(avail), 64'h7);
    chk("flush_dis_valid", 64'(dis_valid), 64'h0);

    // Exception sitting at head+1.
    dis_ready = 2'b00;
    set_lanes(3'b111, 'h200, 4'd3);
    step();
    chk("exc_cut_valid", 64'(dis_valid), 64'h1);
    set_lanes('0, 0, '0);
    dis_ready = 2'b01;
    step();
    chk("exc_alone_valid", 64'(dis_valid), 64'h1);
    chk("exc_alone_pc", 64'(dis_pc[31:0]), 64'h204);
    chk("exc_alone_code", 64'(dis_exc[3:0]), 64'h3);
    step();
    chk("after_exc_pc", 64'(dis_pc[31:0]), 64'h208);
    dis_ready = 2'b11;
    step();

    // Wrap-around: 20 entries through an 8-entry queue keep pc order.
    exp_pc = 'h300; popped = 0; pushed = 0;
    for (int c = 0; c < 40 && popped < 20; c++) begin
      if (pushed < 20) begin
        set_lanes(3'b011, 'h300 + 4 * pushed, '0);
        pushed += 2;
      end else begin
        set_lanes('0, 0, '0);
      end
      dis_ready = 2'b11;
      for (int j = 0; j < ISSUE; j++) begin
        if (dis_valid[j]) begin
          chk("wrap_pc", 64'(dis_ent(j).pc), 64'(exp_pc));
          exp_pc += 4;
          popped++;
        end
      end
      step();
    end
    chk("wrap_popped", 64'(popped), 64'd20);

    pc_ctr = 'h1000;
    for (int c = 0; c < 400; c++) rand_cycle(1'b1, pc_ctr);

    // Asynchronous reset in the middle of a burst at occupancy 5.
    set_lanes('0, 0, '0);
    dis_ready = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_lanes(3'b111, 'h500, '0);
    step();
    set_lanes(3'b011, 'h50c, '0);
    step();
    chk("pre_reset_avail", 64'(avail), 64'h7);
    chk("pre_reset_dis_valid", 64'(dis_valid), 64'h3);
    set_lanes(3'b111, 'h600, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_avail", 64'(avail), 64'h7);
    chk("async_reset_dis_valid", 64'(dis_valid), 64'h0);
    mq.delete();
    @(negedge clk);
    set_lanes('0, 0, '0);
    rst_n = 1'b1;
    check_outputs();
    step();
    chk("post_reset_dis_valid", 64'(dis_valid), 64'h0);

    for (int c = 0; c < 200; c++) rand_cycle(1'b0, pc_ctr);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_buf.md
# inst_buf

In-order instruction buffer sitting between the decoder and rename/dispatch. It is the consumer on the `ib` side of the `decode` interface:
- captures up to WIDTH decoded instructions per cycle into a circular queue;
- throttles fetch/decode through per-lane `avail` credits;
- releases up to ISSUE entries per cycle, oldest first, to dispatch.

It also serialises exception-carrying entries and handles pipeline flushes.

## Interface
- WIDTH, 3, decode lanes per cycle (matches `decode` interface WIDTH)
- ISSUE, 2, dispatch lanes per cycle
- DEPTH, 8, queue entries; power of two, DEPTH >= WIDTH
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ib  `decode.ib` modport  —  decode side:
  - valid, opt, fun, sel, pc, imm, src, dst, exc: inputs
  - avail: output
- flush  in  1  discard all buffered and incoming entries
- dis_valid  out  ISSUE  dispatch lane j holds a valid entry
- dis_opt/dis_fun/dis_sel/dis_pc/dis_imm/dis_src/dis_dst/dis_exc  out  ISSUE x field type  entry fields per dispatch lane
- dis_ready  in  ISSUE  consumer accepts lane j; must be prefix-contiguous

## Operation
- Storage: DEPTH-entry array of {opt, fun, sel, pc, imm, src, dst, exc}.
- Pointers: head and tail, each clog2(DEPTH) bits, wrapping mod DEPTH.
- Occupancy: count, clog2(DEPTH+1) bits.
- Credit: avail[i] = (DEPTH - count) > i.
  - Combinational from registered count only.
  - Same-cycle dequeues never raise avail.
- Enqueue:
  - Lanes with valid[i] & avail[i] write at tail+i in lane order.
  - tail advances by the number written.
  - valid must be prefix-contiguous; a lane with valid & !avail is dropped.
- Dispatch window:
  - dis_valid[j] = (count > j), subject to the exception rule below.
  - Lane j shows entry head+j.
- Exception serialisation:
  - An entry with exc != no-exception is presented only in dispatch lane 0.
  - If it sits at head+j with j > 0, dis_valid is cut to lanes < j.
  - Entries younger than the exception entry are never presented in the same cycle as it.
- Dequeue: head advances by popcount(dis_valid & dis_ready).
- Count update: count_next = count + enq - deq. Enqueue and dequeue in the same cycle are both honoured.
- Flush (highest priority):
  - head, tail and count go to 0.
  - Same-cycle enqueues and dequeues are discarded.
  - dis_valid is not masked in the flush cycle; the consumer owns flush ordering.
- Full: count == DEPTH gives avail = 0.
- Empty: count == 0 gives dis_valid = 0. There is no decode-to-dispatch bypass.

## Timing
- Reset (reset_n low, asynchronous):
  - head = tail = count = 0, so avail = all ones and dis_valid = 0.
  - Array contents are don't-care.
- Reset deasserting mid-stream restarts from empty. Entries written before reset are lost.
- Latency: an entry enqueued in cycle N is visible on dis_* in cycle N+1 at the earliest.
- Throughput: WIDTH in and ISSUE out per cycle sustained. Steady-state stall arises when WIDTH > ISSUE.
- Freed slots become visible as avail one cycle after dequeue.
- Flush in cycle N: avail = all ones and dis_valid = 0 from cycle N+1.
- All outputs are functions of registered state; there is no input-to-output combinational path except none. dis_ready only affects next state.

## Configuration
- IB_PERF_EN defined: adds outputs
  - perf_full_cycles (32 bit): counts cycles with count == DEPTH; saturating.
  - perf_max_occ (clog2(DEPTH+1) bit): occupancy high-water mark.
  - Both reset to 0 on reset_n only; flush does not clear them.
- IB_PERF_EN undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then idle:
  - avail = 3'b111, dis_valid = 2'b00.
  - After 3 valid lanes with pc 0x100/0x104/0x108: next cycle dis_valid = 2'b11 with pc 0x100, 0x104.
- Fill to full:
  - 3 lanes/cycle, dis_ready = 0, DEPTH = 8.
  - Cycle 3: count = 6, avail = 3'b011, lane 2 dropped.
  - Cycle 4: count = 8, avail = 0.
- Simultaneous enqueue and dequeue at count = 8:
  - dis_ready = 2'b11 with valid = 3'b111.
  - No enqueue, count = 6, avail = 3'b011 next cycle.
- Exception serialisation: exc set on entry at head+1.
  - dis_valid = 2'b01; accept it.
  - Next cycle the exception entry is alone in lane 0, with dis_valid = 2'b01.
- Wrap-around and flush:
  - Push and pop 20 entries with pc incrementing by 4; pc order is preserved across the pointer wrap.
  - flush together with valid = 3'b111 leaves count = 0 and avail = 3'b111.
- Asynchronous reset asserted mid-burst with count = 5:
  - Outputs go to their reset values immediately.
  - After release, the queue is empty.
